// File: rtl/systolic_frame_sched.sv
// Frame scheduler for one systolic-array column: a single command frame per 16 slots,
// round-robin choice of requester, and capture of the array's echo frame as the response.
module systolic_frame_sched #(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [8*NREQ-1:0]    req_addr,
  input  logic [64*NREQ-1:0]   req_data,
  output logic [3:0]           col_data,
  output logic                 col_ctrl,
  output logic                 frame_start,
  input  logic [3:0]           echo_data,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [7:0]           rsp_addr,
  output logic [63:0]          rsp_data,
  output logic [15:0]          frames_sent
);

  logic [3:0]     r_slot;
  logic           r_running;
  logic [IDW-1:0] r_lastId;
  logic [15:0]    r_framesSent;

  logic           r_txValid;
  logic [IDW-1:0] r_txId;
  logic [7:0]     r_txAddr;
  logic [63:0]    r_txData;

  logic           r_tagValid;
  logic [IDW-1:0] r_tagId;
  logic [7:0]     r_tagAddr;
  logic [59:0]    r_echoBuf;

  logic           r_rspValid;
  logic [IDW-1:0] r_rspId;
  logic [7:0]     r_rspAddr;
  logic [63:0]    r_rspData;

  logic           w_boundary;
  logic           w_grantValid;
  logic           w_accept;
  logic [IDW-1:0] w_idx;
  logic [IDW-1:0] w_grantId;
  logic [7:0]     w_selAddr;
  logic [63:0]    w_selData;
  logic [5:0]     w_nibLsb;
  logic [15:0]    w_ctrlWord;

  // r_running stays low for the reset cycle so the first live cycle is slot 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot    <= 4'd0;
      r_running <= 1'b0;
    end else begin
      r_running <= 1'b1;
      if (r_running)
        r_slot <= r_slot + 4'd1;
    end
  end

  assign w_boundary = r_running && (r_slot == 4'd15);
  assign w_accept   = w_boundary && en && w_grantValid;

  // Round-robin search beginning one past the last granted requester.
  always_comb begin
    w_grantValid = 1'b0;
    w_grantId    = '0;
    w_idx        = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = IDW'((int'(r_lastId) + 1 + i) % NREQ);
      if (!w_grantValid && req_valid[w_idx]) begin
        w_grantValid = 1'b1;
        w_grantId    = w_idx;
      end
    end
  end

  always_comb begin
    w_selAddr = 8'h00;
    w_selData = 64'h0;
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grantId == IDW'(i)) begin
        w_selAddr = req_addr[8*i +: 8];
        w_selData = req_data[64*i +: 64];
      end
    end
    req_ready[w_grantId] = w_accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_txValid    <= 1'b0;
      r_txId       <= '0;
      r_txAddr     <= 8'h00;
      r_txData     <= 64'h0;
      r_lastId     <= IDW'(NREQ - 1);
      r_framesSent <= 16'h0000;
    end else if (w_boundary) begin
      r_txValid <= w_accept;
      r_txId    <= w_accept ? w_grantId : '0;
      r_txAddr  <= w_accept ? w_selAddr : 8'h00;
      r_txData  <= w_accept ? w_selData : 64'h0;
      if (w_accept) begin
        r_lastId <= w_grantId;
        if (r_framesSent != 16'hFFFF)
          r_framesSent <= r_framesSent + 16'd1;
      end
    end
  end

  // The tag trails the transmitted frame by one frame, matching the array's echo latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tagValid <= 1'b0;
      r_tagId    <= '0;
      r_tagAddr  <= 8'h00;
      r_echoBuf  <= 60'h0;
      r_rspValid <= 1'b0;
      r_rspId    <= '0;
      r_rspAddr  <= 8'h00;
      r_rspData  <= 64'h0;
    end else begin
      r_rspValid <= 1'b0;
      if (r_running)
        r_echoBuf <= {r_echoBuf[55:0], echo_data};
      if (w_boundary) begin
        r_tagValid <= r_txValid;
        r_tagId    <= r_txId;
        r_tagAddr  <= r_txAddr;
        if (r_tagValid) begin
          r_rspValid <= 1'b1;
          r_rspId    <= r_tagId;
          r_rspAddr  <= r_tagAddr;
          r_rspData  <= {r_echoBuf, echo_data};
        end
      end
    end
  end

  assign w_nibLsb   = 6'd60 - {r_slot, 2'b00};
  assign w_ctrlWord = r_txValid ? {r_txAddr, 2'b00, 1'b1, 5'b00000} : 16'h0000;

  assign col_data    = r_txData[w_nibLsb +: 4];
  assign col_ctrl    = w_ctrlWord[4'd15 - r_slot];
  assign frame_start = r_running && (r_slot == 4'd0);
  assign rsp_valid   = r_rspValid;
  assign rsp_id      = r_rspId;
  assign rsp_addr    = r_rspAddr;
  assign rsp_data    = r_rspData;
  assign frames_sent = r_framesSent;

endmodule

// File: tb/tb_systolic_frame_sched.sv
// Randomised bench for systolic_frame_sched, checked every cycle against a frame-level
// model of slots, round-robin grants, echo responses and the saturating frame count.
module tb_systolic_frame_sched;
  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_ready;
  logic [8*NREQ-1:0]   req_addr = '0;
  logic [64*NREQ-1:0]  req_data = '0;
  logic [3:0]          col_data;
  logic                col_ctrl;
  logic                frame_start;
  logic [3:0]          echo_data = 4'h0;
  logic                rsp_valid;
  logic [IDW-1:0]      rsp_id;
  logic [7:0]          rsp_addr;
  logic [63:0]         rsp_data;
  logic [15:0]         frames_sent;

  always #5 clk = ~clk;

  systolic_frame_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .col_data(col_data), .col_ctrl(col_ctrl), .frame_start(frame_start),
    .echo_data(echo_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .frames_sent(frames_sent)
  );

  int testsRun = 0;
  int testsFailed = 0;

  int          mCyc;
  logic [3:0]  expCol[16];
  logic        expCtl[16];
  logic [3:0]  echoCap[16];
  bit          mTxValid;
  int          mTxId;
  logic [7:0]  mTxAddr;
  logic [63:0] mTxData;
  bit          mTagValid;
  int          mTagId;
  logic [7:0]  mTagAddr;
  bit          rspDue;
  int          heldId, nextId;
  logic [7:0]  heldAddr, nextAddr;
  logic [63:0] heldData, nextData;
  int          rrLast;
  logic [15:0] mFrames;

  bit          pend[NREQ];
  logic [7:0]  pendAddr[NREQ];
  logic [63:0] pendData[NREQ];
  int          enMode;
  int          newProb;
  bit          echoLoop;

  logic [3:0]  hist[$];
  int          grantLog[$];
  logic [3:0]  obsCol[$];
  logic        obsCtl[$];
  int          rspCount, readySeen, ctrlSeen;
  int          obsRspId;
  logic [7:0]  obsRspAddr;
  logic [63:0] obsRspData;

  function automatic logic [7:0] randAddr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 0) return 8'h02;
    if (r == 1) return 8'h04;
    return 8'(r + 6);
  endfunction

  // Expected column stream for the frame now on the link, straight from the frame format.
  function automatic void buildFrame();
    logic [63:0] sh;
    logic [15:0] word;
    word = mTxValid ? {mTxAddr, 2'b00, 1'b1, 5'b00000} : 16'h0000;
    for (int k = 0; k < 16; k++) begin
      sh = mTxData >> (60 - 4*k);
      expCol[k] = mTxValid ? sh[3:0] : 4'h0;
      expCtl[k] = word[15-k];
    end
  endfunction

  function automatic void modelReset();
    mCyc = 0; mTxValid = 0; mTxId = 0; mTxAddr = 0; mTxData = 0;
    mTagValid = 0; mTagId = 0; mTagAddr = 0;
    rspDue = 0; heldId = 0; heldAddr = 0; heldData = 0;
    rrLast = NREQ - 1; mFrames = 16'h0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 0; pendAddr[i] = 0; pendData[i] = 0;
    end
    hist.delete();
    buildFrame();
  endfunction

  task automatic runCycle();
    int slot, g, idx;
    logic [3:0] nib;
    logic [NREQ-1:0] expReady;
    logic [63:0] d;
    @(negedge clk);
    slot = mCyc % 16;
    if (rspDue) begin
      heldId = nextId; heldAddr = nextAddr; heldData = nextData;
    end
    testsRun++;
    if (frame_start !== (slot == 0)) begin
      testsFailed++; $display("[TB] FAIL frame_start cyc %0d got %b expected %b", mCyc, frame_start, slot == 0);
    end
    testsRun++;
    if (col_data !== expCol[slot]) begin
      testsFailed++; $display("[TB] FAIL col_data cyc %0d got %h expected %h", mCyc, col_data, expCol[slot]);
    end
    testsRun++;
    if (col_ctrl !== expCtl[slot]) begin
      testsFailed++; $display("[TB] FAIL col_ctrl cyc %0d got %b expected %b", mCyc, col_ctrl, expCtl[slot]);
    end
    testsRun++;
    if (rsp_valid !== rspDue) begin
      testsFailed++; $display("[TB] FAIL rsp_valid cyc %0d got %b expected %b", mCyc, rsp_valid, rspDue);
    end
    testsRun++;
    if (rsp_id !== IDW'(heldId) || rsp_addr !== heldAddr || rsp_data !== heldData) begin
      testsFailed++;
      $display("[TB] FAIL rsp_fields cyc %0d got %h/%h/%h expected %h/%h/%h",
               mCyc, rsp_id, rsp_addr, rsp_data, IDW'(heldId), heldAddr, heldData);
    end
    testsRun++;
    if (frames_sent !== mFrames) begin
      testsFailed++; $display("[TB] FAIL frames_sent cyc %0d got %h expected %h", mCyc, frames_sent, mFrames);
    end
    rspDue = 0;
    if (rsp_valid) begin
      rspCount++; obsRspId = int'(rsp_id); obsRspAddr = rsp_addr; obsRspData = rsp_data;
    end
    obsCol.push_back(col_data);
    obsCtl.push_back(col_ctrl);
    if (col_ctrl) ctrlSeen++;

    // Echo source: either the column stream 16 cycles back (loopback) or random nibbles.
    hist.push_back(col_data);
    if (echoLoop) nib = (hist.size() > 16) ? hist[hist.size()-17] : 4'h0;
    else          nib = 4'($urandom);
    if (hist.size() > 16) void'(hist.pop_front());
    echo_data = nib;
    echoCap[slot] = nib;

    for (int i = 0; i < NREQ; i++) begin
      if (!pend[i] && $urandom_range(0, 99) < newProb) begin
        pend[i] = 1; pendAddr[i] = randAddr(); pendData[i] = {$urandom, $urandom};
      end
      req_valid[i] = pend[i];
      req_addr[8*i +: 8] = pendAddr[i];
      req_data[64*i +: 64] = pendData[i];
    end
    en = (enMode == 2) ? 1'($urandom) : (enMode == 1);

    #1;
    g = -1;
    if (slot == 15 && en)
      for (int j = 0; j < NREQ; j++) begin
        idx = (rrLast + 1 + j) % NREQ;
        if (g < 0 && pend[idx]) g = idx;
      end
    expReady = '0;
    if (g >= 0) expReady[g] = 1'b1;
    testsRun++;
    if (req_ready !== expReady) begin
      testsFailed++; $display("[TB] FAIL req_ready cyc %0d got %b expected %b", mCyc, req_ready, expReady);
    end
    if (req_ready != '0) readySeen++;
    if (slot == 15)
      for (int j = 0; j < NREQ; j++) if (req_ready[j]) grantLog.push_back(j);

    if (slot == 15) begin
      if (mTagValid) begin
        d = 64'h0;
        for (int k = 0; k < 16; k++) d = (d << 4) | 64'(echoCap[k]);
        rspDue = 1; nextId = mTagId; nextAddr = mTagAddr; nextData = d;
      end
      mTagValid = mTxValid; mTagId = mTxId; mTagAddr = mTxAddr;
      if (g >= 0) begin
        mTxValid = 1; mTxId = g; mTxAddr = pendAddr[g]; mTxData = pendData[g];
        pend[g] = 0; rrLast = g;
        if (mFrames != 16'hFFFF) mFrames = mFrames + 16'd1;
      end else begin
        mTxValid = 0; mTxId = 0; mTxAddr = 0; mTxData = 0;
      end
      buildFrame();
    end
    mCyc++;
  endtask

  task automatic doReset();
    rst = 1'b1; en = 1'b1; req_valid = '1;
    @(negedge clk);
    testsRun++;
    if (col_data !== 4'h0 || col_ctrl !== 1'b0 || frame_start !== 1'b0 || req_ready !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_link got %h/%b/%b/%b expected 0/0/0/0", col_data, col_ctrl, frame_start, req_ready);
    end
    testsRun++;
    if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_addr !== 8'h0 || rsp_data !== 64'h0 || frames_sent !== 16'h0) begin
      testsFailed++;
      $display("[TB] FAIL reset_rsp got %b/%h/%h/%h/%h expected all zero", rsp_valid, rsp_id, rsp_addr, rsp_data, frames_sent);
    end
    rst = 1'b0; req_valid = '0;
    modelReset();
  endtask

  task automatic test_reset();
    enMode = 1; newProb = 0; echoLoop = 0;
    doReset();
    runCycle();
    testsRun++;
    if (frame_start !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL first_slot got %b expected 1", frame_start);
    end
  endtask

  task automatic test_idle();
    doReset();
    enMode = 0; newProb = 0; echoLoop = 0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1; pendAddr[i] = randAddr(); pendData[i] = {$urandom, $urandom};
    end
    readySeen = 0; ctrlSeen = 0;
    repeat (64) runCycle();
    testsRun++;
    if (readySeen != 0 || ctrlSeen != 0 || frames_sent !== 16'h0) begin
      testsFailed++; $display("[TB] FAIL idle got ready %0d ctrl %0d frames %h expected 0 0 0", readySeen, ctrlSeen, frames_sent);
    end
  endtask

  task automatic test_single_write();
    logic [15:0] pat;
    pat = 16'b0000_0010_0010_0000;
    doReset();
    enMode = 1; newProb = 0; echoLoop = 0;
    pend[0] = 1; pendAddr[0] = 8'h02; pendData[0] = 64'h0123456789ABCDEF;
    repeat (16) runCycle();
    obsCol.delete(); obsCtl.delete();
    repeat (16) runCycle();
    for (int k = 0; k < 16; k++) begin
      testsRun++;
      if (obsCol[k] !== 4'(k) || obsCtl[k] !== pat[15-k]) begin
        testsFailed++;
        $display("[TB] FAIL single_slot%0d got %h/%b expected %h/%b", k, obsCol[k], obsCtl[k], 4'(k), pat[15-k]);
      end
    end
    runCycle();
    testsRun++;
    if (frames_sent !== 16'd1) begin
      testsFailed++; $display("[TB] FAIL single_frames got %h expected 0001", frames_sent);
    end
  endtask

  task automatic test_fairness();
    doReset();
    enMode = 1; newProb = 100; echoLoop = 0;
    grantLog.delete();
    repeat (64) runCycle();
    runCycle();
    testsRun++;
    if (grantLog.size() != 4 || grantLog[0] != 0 || grantLog[1] != 1 || grantLog[2] != 0 || grantLog[3] != 1) begin
      testsFailed++; $display("[TB] FAIL fairness got %p expected 0,1,0,1", grantLog);
    end
    testsRun++;
    if (frames_sent !== 16'd4) begin
      testsFailed++; $display("[TB] FAIL fairness_frames got %h expected 0004", frames_sent);
    end
  endtask

  task automatic test_echo();
    doReset();
    enMode = 1; newProb = 0; echoLoop = 1;
    pend[1] = 1; pendAddr[1] = 8'h0A; pendData[1] = 64'hFEDCBA9876543210;
    rspCount = 0;
    repeat (64) runCycle();
    testsRun++;
    if (rspCount != 1 || obsRspId != 1 || obsRspAddr !== 8'h0A || obsRspData !== 64'hFEDCBA9876543210) begin
      testsFailed++;
      $display("[TB] FAIL echo got n=%0d %0d/%h/%h expected n=1 1/0a/fedcba9876543210", rspCount, obsRspId, obsRspAddr, obsRspData);
    end
  endtask

  task automatic test_reset_mid_frame();
    doReset();
    enMode = 1; newProb = 0; echoLoop = 1;
    pend[0] = 1; pendAddr[0] = 8'h04; pendData[0] = {$urandom, $urandom};
    repeat (24) runCycle();
    doReset();
    rspCount = 0;
    repeat (64) runCycle();
    testsRun++;
    if (rspCount != 0 || frames_sent !== 16'h0) begin
      testsFailed++; $display("[TB] FAIL midreset got rsp %0d frames %h expected 0 0", rspCount, frames_sent);
    end
  endtask

  task automatic test_back_to_back();
    doReset();
    enMode = 1; newProb = 100; echoLoop = 1;
    grantLog.delete(); rspCount = 0;
    repeat (16*12) runCycle();
    testsRun++;
    if (grantLog.size() != 12 || rspCount != 9) begin
      testsFailed++; $display("[TB] FAIL back_to_back got grants %0d rsps %0d expected 12 9", grantLog.size(), rspCount);
    end
  endtask

  task automatic test_random();
    doReset();
    enMode = 2; newProb = 30; echoLoop = 0;
    repeat (16*40) runCycle();
  endtask

  task automatic test_saturation();
    doReset();
    enMode = 1; newProb = 0; echoLoop = 1;
    repeat (2) runCycle();
    force dut.r_framesSent = 16'hFFFD;
    #1;
    release dut.r_framesSent;
    mFrames = 16'hFFFD;
    newProb = 100;
    repeat (16*4) runCycle();
    runCycle();
    testsRun++;
    if (frames_sent !== 16'hFFFF) begin
      testsFailed++; $display("[TB] FAIL saturation got %h expected ffff", frames_sent);
    end
  endtask

  initial begin
    modelReset();
    test_reset();
    test_idle();
    test_single_write();
    test_fairness();
    test_echo();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/systolic_frame_sched.md
SYSTOLIC_FRAME_SCHED -- requirements
Module: systolic_frame_sched

Interface
REQ-001 SHALL have parameter NREQ, default 2, meaning number of requesters (2..4).
REQ-002 SHALL have parameter IDW, default 1, meaning requester-id width, with 2**IDW >= NREQ.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port en, input, 1: scheduling enable, sampled at frame boundary.
REQ-006 SHALL have port req_valid, input, NREQ: per-requester command valid.
REQ-007 SHALL have port req_ready, output, NREQ: per-requester accept strobe.
REQ-008 SHALL have port req_addr, input, 8*NREQ: target register address per requester (02 A, 04 B, 08-0F C words).
REQ-009 SHALL have port req_data, input, 64*NREQ: 64-bit payload per requester.
REQ-010 SHALL have port col_data, output, 4: nibble driven to array column input.
REQ-011 SHALL have port col_ctrl, output, 1: control bit driven to array column-control input.
REQ-012 SHALL have port frame_start, output, 1: high during slot 0 of every frame.
REQ-013 SHALL have port echo_data, input, 4: column-output nibble returned by the array.
REQ-014 SHALL have port rsp_valid, output, 1: one-cycle response strobe.
REQ-015 SHALL have port rsp_id, output, IDW: requester owning the response.
REQ-016 SHALL have port rsp_addr, output, 8: address of the echoed command.
REQ-017 SHALL have port rsp_data, output, 64: echoed 64-bit frame payload.
REQ-018 SHALL have port frames_sent, output, 16: count of non-idle frames issued.

Function
REQ-019 SHALL run a free-running 4-bit slot counter 0..15, wrapping 15->0; 16 slots form one frame.
REQ-020 SHALL, in slot k, drive col_data = frame payload bits [63-4k:60-4k] and col_ctrl = control word bit [15-k].
REQ-021 SHALL build control word as {addr[7:0], 2'b00, 1'b1 (shift-in), 5'b00000} for command frames; all-zero for idle frames.
REQ-022 SHALL drive idle frames (col_data=0, col_ctrl=0) when no command is accepted or en was low at the boundary.
REQ-023 SHALL assert req_ready only in slot 15, combinationally, to at most one requester, and only if en=1 and that requester's req_valid=1.
REQ-024 SHALL accept on req_valid&req_ready at the slot-15 edge, latching addr/data; the accepted frame is transmitted in the following 16 slots.
REQ-025 SHALL arbitrate round-robin: search starts at (last granted id + 1) mod NREQ; after reset, search starts at id 0.
REQ-026 SHALL update last-granted only on an actual accept; idle frames leave the pointer unchanged.
REQ-027 SHALL require requesters to hold req_valid/addr/data stable until accepted; dropping req_valid before acceptance is a requester protocol error, behaviour unspecified.
REQ-028 SHALL keep a one-deep in-flight tag (valid, id, addr) for the frame just transmitted, moved at each frame boundary.
REQ-029 SHALL sample echo_data at the rising edge ending slot k of the frame following transmission, into rsp_data bits [63-4k:60-4k].
REQ-030 SHALL pulse rsp_valid for one cycle in slot 0 after the echo frame completes, only if the in-flight tag was valid; rsp_id/rsp_addr from the tag, held until next rsp_valid.
REQ-031 SHALL increment frames_sent on each accept, saturating at 16'hFFFF.
REQ-032 SHALL sustain back-to-back command frames (one accept per frame, 100% link utilisation) with overlapping echo capture.

Reset
REQ-033 SHALL, while rst=1: slot=0, col_data=0, col_ctrl=0, frame_start=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_addr=0, rsp_data=0, frames_sent=0, tags invalid, RR pointer to start at id 0.
REQ-034 SHALL, on first cycle after rst falls, be in slot 0 (frame_start=1) transmitting an idle frame; mid-frame reset discards the in-flight command and pending response.

Verification
REQ-035 Idle: en=0, req_valid=11 for 64 cycles -> req_ready never high, col_ctrl=0, frames_sent=0.
REQ-036 Single write: req0 addr 02, data 0123456789ABCDEF -> next frame col_data 0,1,...,F, col_ctrl = 0,0,0,0,0,0,1,0,0,0,1,0,0,0,0,0; frames_sent=1.
REQ-037 Fairness: both valid continuously for 4 frames -> grants 0,1,0,1; frames_sent=4.
REQ-038 Echo: loopback echo_data = col_data delayed 16 cycles, req1 addr 0A data FEDCBA9876543210 -> rsp_valid once, rsp_id=1, rsp_addr=0A, rsp_data=FEDCBA9876543210.
REQ-039 Reset mid-frame: rst at slot 7 of command frame -> outputs zero next cycle, no rsp_valid afterwards, frames_sent=0.
REQ-040 Saturation: force 70000 accepts -> frames_sent holds FFFF.
